multicycle_control_unit: RTL and testbench

Main sequencer of the multicycle CPU. A state machine steps each instruction through IF/ID/EXE/MEM/WB from the 6-bit opcode in the instruction register. It drives every datapath enable and mux select, including the 2-bit PC-source select of the PC address mux and the PC write enable. It sits between the instruction register and the datapath, with one instance per core.

---
 rtl/multicycle_control_unit.sv | 153 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Main sequencer of the multicycle CPU: walks each instruction through IF/ID/EXE/MEM/WB
// and decodes every datapath enable and mux select from (state, opcode, zero).
module multicycle_control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [2:0] state,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       InsMemRW,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc
);

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE  = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b101;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic [2:0] state_q, state_d;
  logic       is_rtype, is_itype, is_jump, is_defined;
  logic       last_c;

  function automatic logic [2:0] alu_op(input logic [5:0] op);
    case (op)
      OP_SUB, OP_BEQ: alu_op = 3'b001;
      OP_SLL:         alu_op = 3'b010;
      OP_OR, OP_ORI:  alu_op = 3'b011;
      OP_AND:         alu_op = 3'b100;
      OP_SLT:         alu_op = 3'b110;
      default:        alu_op = 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] pc_src(input logic [5:0] op, input logic z);
    case (op)
      OP_J, OP_JAL: pc_src = 2'b11;
      OP_JR:        pc_src = 2'b10;
      OP_BEQ:       pc_src = z ? 2'b01 : 2'b00;
      default:      pc_src = 2'b00;
    endcase
  endfunction

  always_comb begin
    is_rtype   = opcode inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT};
    is_itype   = opcode inside {OP_ADDI, OP_ORI, OP_LW};
    is_jump    = opcode inside {OP_J, OP_JR, OP_JAL};
    is_defined = is_rtype || is_itype || is_jump ||
                 (opcode inside {OP_SW, OP_BEQ, OP_HALT});
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   state_d = S_ID;
      S_ID: begin
        if (opcode == OP_HALT)            state_d = S_HALT;
        else if (is_jump || !is_defined)  state_d = S_IF;
        else                              state_d = S_EXE;
      end
      S_EXE: begin
        if (opcode == OP_BEQ)                       state_d = S_IF;
        else if (opcode == OP_SW || opcode == OP_LW) state_d = S_MEM;
        else                                         state_d = S_WB;
      end
      S_MEM:  state_d = (opcode == OP_LW) ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= S_IF;
    else      state_q <= state_d;
  end

  assign state = state_q;

  // Enables are gated by RST so an instruction caught by reset performs no writes.
  always_comb begin
    last_c    = 1'b0;
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    InsMemRW  = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegSrc  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = 3'b000;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;

    case (state_q)
      S_ID:    last_c = is_jump || !is_defined;
      S_EXE:   last_c = (opcode == OP_BEQ);
      S_MEM:   last_c = (opcode == OP_SW);
      S_WB:    last_c = 1'b1;
      default: last_c = 1'b0;
    endcase

    PCWre    = RST && last_c;
    PCSrc    = PCWre ? pc_src(opcode, zero) : 2'b00;
    InsMemRW = RST && (state_q == S_IF);
    IRWre    = RST && (state_q == S_IF);
    RegWre   = RST && ((state_q == S_WB) || (state_q == S_ID && opcode == OP_JAL));
    mWR      = RST && (state_q == S_MEM) && (opcode == OP_SW);
    mRD      = RST && (opcode == OP_LW) && (state_q == S_MEM || state_q == S_WB);

    if (state_q inside {S_ID, S_EXE, S_MEM, S_WB}) begin
      RegDst    = (opcode == OP_JAL) ? 2'b00 : (is_rtype ? 2'b10 : 2'b01);
      WrRegSrc  = (opcode != OP_JAL);
      ALUSrcA   = (opcode == OP_SLL);
      ALUSrcB   = opcode inside {OP_ADDI, OP_ORI, OP_SW, OP_LW};
      ExtSel    = (opcode != OP_ORI);
      ALUOp     = alu_op(opcode);
      DBDataSrc = (opcode == OP_LW);
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed instruction list followed by random
// instruction stream with random resets, checked against a per-instruction step model.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       zero = 1'b0;
  logic [2:0] state;
  logic       PCWre, InsMemRW, IRWre, RegWre, WrRegSrc;
  logic       ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;

  multicycle_control_unit dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .state(state),
    .PCWre(PCWre), .PCSrc(PCSrc), .InsMemRW(InsMemRW), .IRWre(IRWre),
    .RegWre(RegWre), .RegDst(RegDst), .WrRegSrc(WrRegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
    .DBDataSrc(DBDataSrc)
  );

  always #5 CLK = ~CLK;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EXE = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_HALT = 3'd5;
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010,
                         OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010,
                         SLL = 6'b011000, SLT = 6'b100110, SW = 6'b110000,
                         LW = 6'b110001, BEQ = 6'b110100, J = 6'b111000,
                         JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

  logic [5:0] op_tbl [15] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT,
                              SW, LW, BEQ, J, JR, JAL, HALT};

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         rst_step;
  } instr_t;

  instr_t dir_q[$];
  instr_t cur;
  bit     cur_dir;

  int n_cmp = 0;
  int n_bad = 0;

  int step = 0;
  bit halted = 1'b0;
  int halt_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t op=%b step=%0d)",
               tag, obs, exp, $time, opcode, step);
    end
  endtask

  function automatic bit is_def(input logic [5:0] op);
    is_def = 1'b0;
    foreach (op_tbl[i]) if (op_tbl[i] == op) is_def = 1'b1;
  endfunction

  // Cycles an instruction takes, from the cycles-per-instruction table.
  function automatic int plan_len(input logic [5:0] op);
    if (!is_def(op) || op == J || op == JR || op == JAL || op == HALT) plan_len = 2;
    else if (op == BEQ) plan_len = 3;
    else if (op == LW)  plan_len = 5;
    else                plan_len = 4;
  endfunction

  function automatic logic [2:0] plan_state(input logic [5:0] op, input int idx);
    case (idx)
      0: plan_state = ST_IF;
      1: plan_state = ST_ID;
      2: plan_state = ST_EXE;
      3: plan_state = (op == LW || op == SW) ? ST_MEM : ST_WB;
      default: plan_state = ST_WB;
    endcase
  endfunction

  function automatic logic [2:0] exp_aluop(input logic [5:0] op);
    case (op)
      SUB, BEQ: exp_aluop = 3'b001;
      SLL:      exp_aluop = 3'b010;
      OR_, ORI: exp_aluop = 3'b011;
      AND_:     exp_aluop = 3'b100;
      SLT:      exp_aluop = 3'b110;
      default:  exp_aluop = 3'b000;
    endcase
  endfunction

  task automatic check_outputs();
    logic [2:0] st;
    bit en, last, rw, rtype;
    logic [1:0] psrc;
    en    = RST;
    st    = halted ? ST_HALT : plan_state(opcode, step);
    last  = !halted && (opcode != HALT) && (step == plan_len(opcode) - 1);
    rtype = opcode inside {ADD, SUB, OR_, AND_, SLL, SLT};
    psrc  = 2'b00;
    if (en && last) begin
      if (opcode == J || opcode == JAL) psrc = 2'b11;
      else if (opcode == JR)            psrc = 2'b10;
      else if (opcode == BEQ && zero)   psrc = 2'b01;
    end
    rw = en && (st == ST_WB || (st == ST_ID && opcode == JAL));
    chk("state", state, st);
    chk("PCWre", PCWre, en && last);
    chk("PCSrc", PCSrc, psrc);
    chk("InsMemRW", InsMemRW, en && st == ST_IF);
    chk("IRWre", IRWre, en && st == ST_IF);
    chk("RegWre", RegWre, rw);
    chk("mWR", mWR, en && st == ST_MEM && opcode == SW);
    chk("mRD", mRD, en && opcode == LW && (st == ST_MEM || st == ST_WB));
    if (rw) begin
      chk("RegDst", RegDst, (opcode == JAL) ? 2'b00 : (rtype ? 2'b10 : 2'b01));
      chk("WrRegSrc", WrRegSrc, opcode != JAL);
    end
    if (st == ST_EXE || st == ST_MEM || st == ST_WB) begin
      chk("ALUSrcA", ALUSrcA, opcode == SLL);
      chk("ALUSrcB", ALUSrcB, opcode inside {ADDI, ORI, SW, LW});
      chk("ExtSel", ExtSel, opcode != ORI);
      chk("ALUOp", ALUOp, exp_aluop(opcode));
      chk("DBDataSrc", DBDataSrc, opcode == LW);
    end
  endtask

  task automatic advance_model();
    if (!RST) begin
      step = 0; halted = 1'b0; halt_cnt = 0;
    end else if (halted) begin
      halt_cnt++;
    end else if (step == 1 && opcode == HALT) begin
      halted = 1'b1; halt_cnt = 1;
    end else if (step == plan_len(opcode) - 1) begin
      step = 0;
    end else begin
      step++;
    end
  endtask

  task automatic drive_inputs();
    bit rst_now;
    if (!halted && step == 0) begin
      if (dir_q.size() > 0) begin
        cur = dir_q.pop_front();
        cur_dir = 1'b1;
      end else begin
        cur_dir = 1'b0;
        cur.rst_step = -1;
        cur.z = 1'b0;
        if ($urandom_range(0, 7) == 0) cur.op = 6'($urandom);
        else cur.op = op_tbl[$urandom_range(0, 14)];
      end
      opcode = cur.op;
    end
    zero = cur_dir ? cur.z : 1'($urandom_range(0, 1));
    rst_now = 1'b0;
    if (!halted && cur.rst_step == step) rst_now = 1'b1;
    if (halted && halt_cnt >= 12) rst_now = 1'b1;
    if (!cur_dir && $urandom_range(0, 63) == 0) rst_now = 1'b1;
    RST = !rst_now;
  endtask

  initial begin
    dir_q.push_back('{ADD, 1'b0, -1});
    dir_q.push_back('{LW, 1'b0, -1});
    dir_q.push_back('{SW, 1'b0, -1});
    dir_q.push_back('{BEQ, 1'b1, -1});
    dir_q.push_back('{BEQ, 1'b0, -1});
    dir_q.push_back('{J, 1'b0, -1});
    dir_q.push_back('{JR, 1'b0, -1});
    dir_q.push_back('{JAL, 1'b0, -1});
    dir_q.push_back('{HALT, 1'b0, -1});
    dir_q.push_back('{SW, 1'b0, 3});
    dir_q.push_back('{6'b101010, 1'b0, -1});
    cur = '{ADD, 1'b0, -1};
    cur_dir = 1'b1;

    RST = 1'b0;
    opcode = ADD;
    @(posedge CLK);
    @(negedge CLK);
    check_outputs();
    @(posedge CLK);
    advance_model();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      #1;
      drive_inputs();
      @(negedge CLK);
      check_outputs();
      @(posedge CLK);
      advance_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
